// File: rtl/irq_pkg.sv
// Shared types and constants for the three-source interrupt claim block.
// Holds the claim FSM enum, source ids and the priority pick helper.
package irq_pkg;

    localparam int IRQ_NSRC = 3;

    localparam logic [1:0] IRQ_ID_A    = 2'd0;
    localparam logic [1:0] IRQ_ID_B    = 2'd1;
    localparam logic [1:0] IRQ_ID_C    = 2'd2;
    localparam logic [1:0] IRQ_ID_NONE = 2'd3;

    typedef enum logic {
        IDLE,
        ANSWER
    } claim_state_t;

    // Lowest bit index wins: a > b > c.
    function automatic logic [1:0] irq_pick(
        input logic [IRQ_NSRC-1:0] req
    );
        if (req[0])      return IRQ_ID_A;
        else if (req[1]) return IRQ_ID_B;
        else if (req[2]) return IRQ_ID_C;
        else             return IRQ_ID_NONE;
    endfunction

endpackage

// File: rtl/irq_edge_cap.sv
// Per-source request capture: sticky rising-edge or plain level follow.
// Ports: clk, rstn (sync, active-low), src, clr, edge_mode -> pending.
module irq_edge_cap (
    input  logic clk,
    input  logic rstn,
    input  logic src,
    input  logic clr,
    input  logic edge_mode,
    output logic pending
);

    logic prev;

    // prev resets high so a line already asserted at release is no edge.
    // A fresh edge beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            prev    <= 1'b1;
            pending <= 1'b0;
        end else begin
            prev <= src;
            if (edge_mode)
                pending <= (src & ~prev) | (pending & ~clr);
            else
                pending <= src;
        end
    end

endmodule

// File: rtl/irq_claim3.sv
// Three-source interrupt collector with registered irq and claim responder.
// Ports: src_a/b/c, mask_wdata/mask_we, irq, claim_req, id_valid/id/id_ready.
module irq_claim3
    import irq_pkg::*;
#(
    parameter bit EDGE_MODE = 1'b1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       src_a,
    input  logic       src_b,
    input  logic       src_c,
    input  logic [2:0] mask_wdata,
    input  logic       mask_we,
    output logic       irq,
    input  logic       claim_req,
    output logic       id_valid,
    output logic [1:0] id,
    input  logic       id_ready
);

    logic [IRQ_NSRC-1:0] src_vec;
    logic [IRQ_NSRC-1:0] pending;
    logic [IRQ_NSRC-1:0] mask;
    logic [IRQ_NSRC-1:0] live;
    logic [IRQ_NSRC-1:0] clr;
    logic                hs;

    claim_state_t state;
    claim_state_t state_nxt;

    assign src_vec = {src_c, src_b, src_a};
    assign live    = pending & ~mask;

    for (genvar gi = 0; gi < IRQ_NSRC; gi++) begin : g_cap
        irq_edge_cap u_cap (
            .clk       (clk),
            .rstn      (rstn),
            .src       (src_vec[gi]),
            .clr       (clr[gi]),
            .edge_mode (EDGE_MODE),
            .pending   (pending[gi])
        );
    end

    always_ff @(posedge clk) begin
        if (!rstn)
            mask <= '1;
        else if (mask_we)
            mask <= mask_wdata;
    end

    always_ff @(posedge clk) begin
        if (!rstn)
            irq <= 1'b0;
        else
            irq <= |live;
    end

    always_ff @(posedge clk) begin
        if (!rstn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (claim_req) state_nxt = ANSWER;
            ANSWER:  if (id_ready)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // id is snapshotted at claim time, so later mask writes or new
    // edges cannot change the answer being presented.
    always_ff @(posedge clk) begin
        if (!rstn)
            id <= IRQ_ID_A;
        else if (state == IDLE && claim_req)
            id <= irq_pick(live);
    end

    always_comb begin
        id_valid = (state == ANSWER);
        hs       = id_valid & id_ready;
        clr      = '0;
        for (int i = 0; i < IRQ_NSRC; i++)
            clr[i] = hs && (id == 2'(i));
    end

endmodule

// File: tb/tb_irq_claim3.sv
// Directed bench for irq_claim3 with a per-cycle reference model.
// Checks irq/id_valid/id every cycle plus literal expectations.
module tb_irq_claim3;

    logic       clk;
    logic       rstn;
    logic       src_a, src_b, src_c;
    logic [2:0] mask_wdata;
    logic       mask_we;
    logic       irq;
    logic       claim_req;
    logic       id_valid;
    logic [1:0] id;
    logic       id_ready;

    int n_cmp = 0;
    int n_bad = 0;

    irq_claim3 #(.EDGE_MODE(1'b1)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .src_a      (src_a),
        .src_b      (src_b),
        .src_c      (src_c),
        .mask_wdata (mask_wdata),
        .mask_we    (mask_we),
        .irq        (irq),
        .claim_req  (claim_req),
        .id_valid   (id_valid),
        .id         (id),
        .id_ready   (id_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // Reference model: what the spec says the state is after each edge.
    bit [2:0] m_pend, m_prev, m_mask;
    bit       m_irq, m_busy, m_on;
    bit [1:0] m_id;

    always @(posedge clk) begin
        bit [2:0] s, live, nxt;
        int sel;
        bit hs;
        s = {src_c, src_b, src_a};
        if (!rstn) begin
            m_pend = 3'b000;
            m_prev = 3'b111;
            m_mask = 3'b111;
            m_irq  = 1'b0;
            m_busy = 1'b0;
            m_id   = 2'd0;
            m_on   = 1'b1;
        end else begin
            live = m_pend & ~m_mask;
            sel = 3;
            for (int i = 2; i >= 0; i--)
                if (live[i]) sel = i;
            hs = m_busy && id_ready;
            for (int i = 0; i < 3; i++)
                nxt[i] = (s[i] && !m_prev[i]) ||
                         (m_pend[i] && !(hs && m_id == 2'(i)));
            m_irq = (live != 3'b000);
            if (!m_busy) begin
                if (claim_req) begin
                    m_busy = 1'b1;
                    m_id   = 2'(sel);
                end
            end else if (id_ready) begin
                m_busy = 1'b0;
            end
            if (mask_we) m_mask = mask_wdata;
            m_pend = nxt;
            m_prev = s;
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            check("model_irq", int'(irq), int'(m_irq));
            check("model_id_valid", int'(id_valid), int'(m_busy));
            if (m_busy)
                check("model_id", int'(id), int'(m_id));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_mask(input logic [2:0] m);
        mask_wdata = m;
        mask_we = 1'b1;
        tick();
        mask_we = 1'b0;
    endtask

    task automatic claim();
        claim_req = 1'b1;
        tick();
        claim_req = 1'b0;
    endtask

    task automatic accept();
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
    endtask

    initial begin
        rstn = 1'b0;
        {src_a, src_b, src_c} = 3'b000;
        mask_wdata = 3'b000;
        mask_we = 1'b0;
        claim_req = 1'b0;
        id_ready = 1'b0;
        repeat (3) tick();
        rstn = 1'b1;
        tick();
        check("rst_irq", int'(irq), 0);
        check("rst_id_valid", int'(id_valid), 0);
        check("rst_id", int'(id), 0);

        // Single b pulse, claim, accept.
        wr_mask(3'b000);
        src_b = 1'b1;
        tick();
        src_b = 1'b0;
        check("b_irq_n1", int'(irq), 0);
        tick();
        check("b_irq_n2", int'(irq), 1);
        claim();
        check("b_valid", int'(id_valid), 1);
        check("b_id", int'(id), 1);
        accept();
        check("b_valid_drop", int'(id_valid), 0);
        check("b_irq_k1", int'(irq), 1);
        tick();
        check("b_irq_k2", int'(irq), 0);

        // All three together: claimed in priority order.
        {src_a, src_b, src_c} = 3'b111;
        tick();
        {src_a, src_b, src_c} = 3'b000;
        tick();
        for (int k = 0; k < 3; k++) begin
            claim();
            check("all_id", int'(id), k);
            accept();
            tick();
            check("all_irq", int'(irq), (k < 2) ? 1 : 0);
        end

        // Masked a: irq stays low, claim is spurious.
        wr_mask(3'b001);
        src_a = 1'b1;
        tick();
        src_a = 1'b0;
        tick();
        tick();
        check("mask_irq", int'(irq), 0);
        claim();
        check("mask_id", int'(id), 3);
        accept();
        wr_mask(3'b000);
        check("unmask_irq_w1", int'(irq), 0);
        tick();
        check("unmask_irq_w2", int'(irq), 1);
        claim();
        check("unmask_id", int'(id), 0);
        accept();
        tick();

        // Stalled answer: c presented, a arrives meanwhile.
        src_c = 1'b1;
        tick();
        src_c = 1'b0;
        tick();
        claim();
        for (int j = 0; j < 5; j++) begin
            src_a = (j == 1);
            if (j == 2) begin
                mask_wdata = 3'b100;
                mask_we = 1'b1;
            end else begin
                mask_we = 1'b0;
            end
            check("stall_valid", int'(id_valid), 1);
            check("stall_id", int'(id), 2);
            tick();
        end
        src_a = 1'b0;
        mask_we = 1'b0;
        accept();
        wr_mask(3'b000);
        claim();
        check("after_stall_id", int'(id), 0);
        accept();
        tick();
        tick();
        check("after_stall_irq", int'(irq), 0);

        // New c edge in the very handshake cycle clearing c.
        src_c = 1'b1;
        tick();
        src_c = 1'b0;
        tick();
        claim();
        check("reedge_id", int'(id), 2);
        id_ready = 1'b1;
        src_c = 1'b1;
        tick();
        id_ready = 1'b0;
        src_c = 1'b0;
        tick();
        check("reedge_irq", int'(irq), 1);
        claim();
        check("reedge_id2", int'(id), 2);
        accept();
        tick();
        check("reedge_irq_end", int'(irq), 0);

        // Reset while an answer is outstanding.
        src_b = 1'b1;
        tick();
        src_b = 1'b0;
        tick();
        claim();
        check("rstmid_valid_pre", int'(id_valid), 1);
        rstn = 1'b0;
        tick();
        check("rstmid_valid", int'(id_valid), 0);
        check("rstmid_irq", int'(irq), 0);
        rstn = 1'b1;
        claim();
        check("rstmid_id", int'(id), 3);
        accept();
        wr_mask(3'b000);
        tick();
        tick();
        check("rstmid_pend", int'(irq), 0);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
